// File: rtl/uart_pkg.sv
// Shared UART timing definitions: baud codes, scheduler states, divider terminal counts.
// Pure declarations, no state; consumed by baud_sched and baud_divider.
package uart_pkg;

    localparam int CLK_HZ     = 50_000_000;
    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 11;

    typedef enum logic [1:0] {
        BAUD24  = 2'b00,
        BAUD48  = 2'b01,
        BAUD96  = 2'b10,
        BAUD192 = 2'b11
    } baud_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_APPLY = 2'b10
    } sched_state_t;

    localparam baud_t BAUD_RESET = BAUD96;

    function automatic int baud_rate(input baud_t b);
        case (b)
            BAUD24:  return 2400;
            BAUD48:  return 4800;
            BAUD96:  return 9600;
            BAUD192: return 19200;
            default: return 9600;
        endcase
    endfunction

    // Nearest-integer divide, so 9600 lands on 326 cycles per tick16 rather than 325.
    function automatic logic [DIV_W-1:0] baud_tc(input baud_t b);
        int step;
        int divisor;
        step    = OVERSAMPLE * baud_rate(b);
        divisor = (CLK_HZ + step / 2) / step;
        return DIV_W'(divisor - 1);
    endfunction

endpackage

// File: rtl/baud_divider.sv
// 16x oversample divider: tick16 every tc+1 cycles, bit_tick on every 16th tick16.
// Outputs registered; clear or enable low zeroes the counters the same cycle, no backpressure.
module baud_divider
    import uart_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] tc,
    output logic             tick16,
    output logic             bit_tick
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic [3:0]       sub;
    logic             en_q;
    logic             run;
    logic             hit_tc;

    // Counting starts one cycle after enable rises, so the first period after resume is a full tc+1.
    assign run     = enable && en_q && !clear;
    assign cnt_inc = div_cnt + 1'b1;
    assign hit_tc  = (cnt_inc == tc);

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= enable;
        end
    end

    // tick16 is registered so it is high during exactly the cycle in which div_cnt sits at tc.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            div_cnt  <= '0;
            sub      <= '0;
            tick16   <= 1'b0;
            bit_tick <= 1'b0;
        end else if (div_cnt == tc) begin
            div_cnt  <= '0;
            sub      <= sub + 1'b1;
            tick16   <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            div_cnt  <= cnt_inc;
            tick16   <= hit_tc;
            bit_tick <= hit_tc && (sub == 4'hF);
        end
    end

endmodule

// File: rtl/baud_sched.sv
// Baud-rate scheduler: accepts rate changes and applies them only when both UART directions are idle.
// Change takes effect 2 cycles after accept with idle lines; cfg_ready low from accept until applied.
module baud_sched
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_baud,
    output logic       cfg_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic [1:0] baud_sel,
    output logic       tick16,
    output logic       bit_tick,
    output logic       cfg_pending
);

    sched_state_t state;
    sched_state_t state_nxt;
    baud_t        baud_q;
    baud_t        pend_baud;
    logic         apply;
    logic         lines_idle;

    assign lines_idle = !tx_busy && !rx_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (cfg_valid)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (lines_idle) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        cfg_ready   = (state == ST_RUN);
        cfg_pending = (state == ST_DRAIN) || (state == ST_APPLY);
        apply       = (state == ST_APPLY);
    end

    // Same-rate requests still go through APPLY so the divider phase restarts.
    always_ff @(posedge clock) begin
        if (reset) begin
            baud_q    <= BAUD_RESET;
            pend_baud <= BAUD_RESET;
        end else begin
            if (cfg_valid && cfg_ready) begin
                pend_baud <= baud_t'(cfg_baud);
            end
            if (apply) begin
                baud_q <= pend_baud;
            end
        end
    end

    assign baud_sel = baud_q;

    baud_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .clear    (apply),
        .tc       (baud_tc(baud_q)),
        .tick16   (tick16),
        .bit_tick (bit_tick)
    );

endmodule

// File: tb/tb_baud_sched.sv
// Bench for baud_sched: scoreboard of expected rate applications plus tick timing checks.
module tb_baud_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic [1:0] cfg_baud;
    logic       cfg_ready;
    logic       tx_busy;
    logic       rx_busy;
    logic [1:0] baud_sel;
    logic       tick16;
    logic       bit_tick;
    logic       cfg_pending;

    baud_sched dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_baud    (cfg_baud),
        .cfg_ready   (cfg_ready),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .baud_sel    (baud_sel),
        .tick16      (tick16),
        .bit_tick    (bit_tick),
        .cfg_pending (cfg_pending)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int baud;
        int cyc;
    } apply_t;

    apply_t exp_q[$];
    apply_t mon_e;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: an apply is seen as cfg_pending falling outside reset.
    logic prev_pend = 1'b0;
    logic prev_tick = 1'b0;
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            if (prev_pend && !cfg_pending) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_apply", cyc, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("apply_cycle", cyc, mon_e.cyc);
                    check_eq("apply_baud", int'(baud_sel), mon_e.baud);
                end
            end
            if (tick16)   check_eq("tick_back_to_back", int'(prev_tick), 0);
            if (bit_tick) check_eq("bit_without_tick", int'(tick16), 1);
        end
        prev_pend = cfg_pending;
        prev_tick = tick16;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tick_wait(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (tick16) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic bit_wait(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (bit_tick) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step(3);
        check_eq("rst_baud_sel", int'(baud_sel), 2);
        check_eq("rst_tick16", int'(tick16), 0);
        check_eq("rst_bit_tick", int'(bit_tick), 0);
        check_eq("rst_pending", int'(cfg_pending), 0);
        reset = 1'b0;
        check_eq("ready_after_reset", int'(cfg_ready), 1);
    endtask

    // Drives one request; linger_baud >= 0 keeps cfg_valid up one more cycle with a different rate.
    task automatic handshake(input int b, input int linger_baud, input bit lines_free, output int n_edge);
        cfg_valid = 1'b1;
        cfg_baud  = 2'(b);
        check_eq("ready_before_req", int'(cfg_ready), 1);
        @(posedge clock);
        #1;
        n_edge = cyc;
        if (lines_free) exp_q.push_back('{b, n_edge + 2});
        check_eq("ready_in_drain", int'(cfg_ready), 0);
        check_eq("pending_in_drain", int'(cfg_pending), 1);
        if (linger_baud >= 0) begin
            cfg_baud = 2'(linger_baud);
            step(1);
            check_eq("pending_ignores_req", int'(cfg_pending), 1);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        int t, t2, tb1, tb2, e0, n, prev, lost, ticks;
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_baud  = 2'b00;
        tx_busy   = 1'b0;
        rx_busy   = 1'b0;
        do_reset();

        // 9600 after reset: tick every 326, bit every 5216
        enable = 1'b1;
        e0 = cyc;
        tick_wait(400, t);
        check_eq("first_tick_after_enable", t - e0, 326);
        check_eq("baud_sel_9600", int'(baud_sel), 2);
        prev = t;
        tick_wait(400, t);
        check_eq("tick_period_9600", t - prev, 326);
        bit_wait(6000, tb1);
        check_eq("first_bit_tick", tb1 - e0, 5216);
        bit_wait(6000, tb2);
        check_eq("bit_period_9600", tb2 - tb1, 5216);

        // 19200 with idle lines; the lingering request must be ignored
        tick_wait(400, t);
        handshake(3, 1, 1'b1, n);
        tick_wait(400, t);
        check_eq("first_tick_19200", t - n, 164);
        prev = t;
        tick_wait(200, t);
        check_eq("tick_period_19200", t - prev, 163);
        check_eq("baud_sel_19200", int'(baud_sel), 3);

        // same rate re-request restarts the phase
        tick_wait(200, t);
        handshake(3, -1, 1'b1, n);
        tick_wait(200, t2);
        check_eq("restart_phase", t2 - n, 164);

        // reset in the middle of DRAIN discards the change
        tick_wait(200, t);
        rx_busy = 1'b1;
        handshake(1, -1, 1'b0, n);
        step(20);
        check_eq("pending_rx_busy", int'(cfg_pending), 1);
        do_reset();
        rx_busy = 1'b0;
        e0 = cyc;
        tick_wait(400, t);
        check_eq("tick_after_reset", t - e0, 326);
        check_eq("pending_after_reset", int'(cfg_pending), 0);

        // 2400 held off by tx_busy for 2000 cycles
        tick_wait(400, t);
        tx_busy = 1'b1;
        handshake(0, -1, 1'b0, n);
        prev  = t;
        lost  = 0;
        ticks = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (!cfg_pending) lost++;
            if (tick16) begin
                check_eq("drain_tick_period", cyc - prev, 326);
                prev = cyc;
                ticks++;
            end
        end
        check_eq("drain_pending_held", lost, 0);
        check_eq("drain_tick_count", ticks, 6);
        check_eq("drain_baud_old", int'(baud_sel), 2);
        tick_wait(400, t);
        tx_busy = 1'b0;
        exp_q.push_back('{0, t + 2});
        tick_wait(1500, t2);
        check_eq("first_tick_2400", t2 - t, 1303);
        prev = t2;
        tick_wait(1500, t2);
        check_eq("tick_period_2400", t2 - prev, 1302);

        // tx idle while rx still busy must not apply
        tick_wait(1500, t);
        tx_busy = 1'b1;
        rx_busy = 1'b1;
        handshake(1, -1, 1'b0, n);
        step(50);
        tx_busy = 1'b0;
        step(100);
        check_eq("rx_holds_drain", int'(cfg_pending), 1);
        check_eq("rx_holds_baud", int'(baud_sel), 0);
        tick_wait(1500, t);
        rx_busy = 1'b0;
        exp_q.push_back('{1, t + 2});
        tick_wait(1500, t2);
        check_eq("first_tick_4800", t2 - t, 652);
        prev = t2;
        tick_wait(1000, t2);
        check_eq("tick_period_4800", t2 - prev, 651);

        // enable low for 500 cycles mid-count; handshake still works
        step(100);
        enable = 1'b0;
        handshake(2, -1, 1'b1, n);
        ticks = 0;
        for (int i = 0; i < 499; i++) begin
            step(1);
            if (tick16 || bit_tick) ticks++;
        end
        check_eq("no_ticks_disabled", ticks, 0);
        check_eq("baud_sel_while_disabled", int'(baud_sel), 2);
        e0 = cyc;
        enable = 1'b1;
        tick_wait(400, t);
        check_eq("tick_after_enable_rise", t - e0, 326);

        step(5);
        check_eq("apply_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
